// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared widths, types and latency constants for the hazard
// scoreboard slice (hazard_scoreboard_if, hazard_reg_counter,
// hazard_scoreboard).
package hazard_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_SRC    = 2;
  localparam int LAT_W      = 3;
  localparam int WB_LAT     = 2;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int MAX_LAT    = 2 ** LAT_W - 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [LAT_W-1:0]      lat_t;

  localparam lat_t LAT_ALU  = lat_t'(0);
  localparam lat_t LAT_LOAD = lat_t'(1);
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage <-> scoreboard bundle.
//   master (ID stage): drives id_valid, id_src, id_src_used, id_wb_en,
//                      id_dest, id_lat, forward_EN, flush;
//                      receives hazard_detected, hazard_src, pending.
//   slave  (scoreboard): the mirror image.
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int NUM_SRC    = hazard_pkg::NUM_SRC,
  parameter int LAT_W      = hazard_pkg::LAT_W
) ();
  localparam int NREGS = 2 ** REG_ADDR_W;

  logic                          id_valid;
  logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
  logic [NUM_SRC-1:0]            id_src_used;
  logic                          id_wb_en;
  logic [REG_ADDR_W-1:0]         id_dest;
  logic [LAT_W-1:0]              id_lat;
  logic                          forward_EN;
  logic                          flush;
  logic                          hazard_detected;
  logic [NUM_SRC-1:0]            hazard_src;
  logic [NREGS-1:0]              pending;

  modport master (
    output id_valid, id_src, id_src_used, id_wb_en, id_dest, id_lat,
           forward_EN, flush,
    input  hazard_detected, hazard_src, pending
  );

  modport slave (
    input  id_valid, id_src, id_src_used, id_wb_en, id_dest, id_lat,
           forward_EN, flush,
    output hazard_detected, hazard_src, pending
  );
endinterface

// File: rtl/hazard_scoreboard_reg_counter.sv
// hazard_reg_counter: countdown for one architectural register.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   load_i     : an issuing instruction writes this register
//   lat_i      : effective latency of that write
//   cnt_o      : cycles until the pending result is consumable
// Each cycle the count drops by one (floor 0); a load keeps the larger of
// the decremented count and the new latency so an older, slower write
// stays protected.
module hazard_reg_counter
  import hazard_pkg::*;
#(
  parameter int LAT_W = hazard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic [LAT_W-1:0] cnt_o
);
  logic [LAT_W-1:0] cnt_q, cnt_d, dec;

  always_comb begin
    dec   = (cnt_q == '0) ? '0 : cnt_q - LAT_W'(1);
    cnt_d = dec;
    if (load_i && (lat_i > dec)) cnt_d = lat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard for the ID stage.
//   clk, rst_n : clock, async active-low reset
//   bus        : hazard_scoreboard_if.slave (ID request in, hazard/pending out)
//   stall_cycles, stall_events : only with HAZARD_STATS_EN defined
// Hazards are evaluated from registered counts only, so an instruction
// never sees its own write (no self-hazard on src == dest).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int NUM_SRC    = hazard_pkg::NUM_SRC,
  parameter int LAT_W      = hazard_pkg::LAT_W,
  parameter int WB_LAT     = hazard_pkg::WB_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [15:0]         stall_events
`endif
);
  localparam int NREGS   = 2 ** REG_ADDR_W;
  localparam int MAX_L   = 2 ** LAT_W - 1;
  localparam int WB_CLMP = (WB_LAT > MAX_L) ? MAX_L : WB_LAT;

  logic [NREGS-1:0][LAT_W-1:0] cnt;
  logic [NUM_SRC-1:0]          haz_src;
  logic                        hazard, fire;
  logic [LAT_W-1:0]            eff_lat;

  always_comb begin
    haz_src = '0;
    for (int k = 0; k < NUM_SRC; k++)
      haz_src[k] = bus.id_valid & bus.id_src_used[k] &
                   (cnt[bus.id_src[k*REG_ADDR_W +: REG_ADDR_W]] != '0);
  end

  assign hazard  = (|haz_src) & ~bus.flush;
  assign fire    = bus.id_valid & ~hazard & ~bus.flush;
  assign eff_lat = bus.forward_EN ? bus.id_lat : LAT_W'(WB_CLMP);

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    hazard_reg_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (fire & bus.id_wb_en & (bus.id_dest == REG_ADDR_W'(r))),
      .lat_i  (eff_lat),
      .cnt_o  (cnt[r])
    );
    assign bus.pending[r] = (cnt[r] != '0);
  end

  assign bus.hazard_src      = haz_src;
  assign bus.hazard_detected = hazard;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] stall_events_q;
  logic        haz_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      stall_events_q <= '0;
      haz_prev_q     <= 1'b0;
    end else begin
      haz_prev_q <= hazard;
      if (hazard && !(&stall_cycles_q))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (hazard && !haz_prev_q && !(&stall_events_q))
        stall_events_q <= stall_events_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign stall_events = stall_events_q;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle against a countdown-array
// model of the register scoreboard.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if bus ();
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] stall_events;
`endif

  hazard_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .stall_events (stall_events)
`endif
  );

  int tests = 0;
  int fails = 0;

  // reference state: remaining cycles per register, stall statistics
  int     mcnt[NUM_REGS];
  longint m_cyc;
  longint m_evt;
  bit     m_prev;

  // copies of the inputs currently applied
  bit       c_v, c_wb, c_fwd, c_fl;
  bit [1:0] c_used;
  int       c_s0, c_s1, c_dest, c_lat;

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (mcnt[r]) mcnt[r] = 0;
    m_cyc = 0; m_evt = 0; m_prev = 0;
  endtask

  task automatic drive(bit v, int s0, int s1, bit [1:0] used, bit wb,
                       int dest, int lat, bit fwd, bit fl);
    c_v = v; c_s0 = s0; c_s1 = s1; c_used = used; c_wb = wb;
    c_dest = dest; c_lat = lat; c_fwd = fwd; c_fl = fl;
    bus.id_valid    = v;
    bus.id_src      = {REG_ADDR_W'(s1), REG_ADDR_W'(s0)};
    bus.id_src_used = used;
    bus.id_wb_en    = wb;
    bus.id_dest     = REG_ADDR_W'(dest);
    bus.id_lat      = LAT_W'(lat);
    bus.forward_EN  = fwd;
    bus.flush       = fl;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
  endtask

  // Compare against the model for the applied inputs, then advance one edge.
  task automatic cyc();
    bit [1:0]          ehs;
    bit                ehaz, fire;
    bit [NUM_REGS-1:0] ep;
    int                L, d;
    ehs[0] = c_v && c_used[0] && (mcnt[c_s0] > 0);
    ehs[1] = c_v && c_used[1] && (mcnt[c_s1] > 0);
    ehaz   = (ehs != 0) && !c_fl;
    for (int r = 0; r < NUM_REGS; r++) ep[r] = (mcnt[r] > 0);
    chk("hazard_src", bus.hazard_src, ehs);
    chk("hazard_detected", bus.hazard_detected, ehaz);
    chk("pending", bus.pending, ep);
`ifdef HAZARD_STATS_EN
    chk("stall_cycles", stall_cycles, m_cyc);
    chk("stall_events", stall_events, m_evt);
`endif
    @(posedge clk);
    fire = c_v && !ehaz && !c_fl;
    L = c_fwd ? c_lat : WB_LAT;
    if (L > MAX_LAT) L = MAX_LAT;
    for (int r = 0; r < NUM_REGS; r++) begin
      d = (mcnt[r] > 0) ? mcnt[r] - 1 : 0;
      if (fire && c_wb && c_dest == r && L > d) d = L;
      mcnt[r] = d;
    end
    if (ehaz && m_cyc < 64'hFFFF_FFFF) m_cyc++;
    if (ehaz && !m_prev && m_evt < 16'hFFFF) m_evt++;
    m_prev = ehaz;
    @(negedge clk);
  endtask

  task automatic drain(int n);
    idle();
    repeat (n) cyc();
  endtask

  initial begin
    bit [NUM_REGS-1:0] pv;
    model_clear();
    idle();
    repeat (2) @(negedge clk);
    chk("reset_pending", bus.pending, 0);
    chk("reset_hazard", bus.hazard_detected, 0);
    rst_n = 1'b1;

    // forwarding off: ADD R1 then consumer stalls 2 cycles
    drive(1, 0, 0, 2'b00, 1, 1, LAT_ALU, 0, 0); cyc();
    drive(1, 1, 1, 2'b11, 1, 2, LAT_ALU, 0, 0);
    chk("nofwd_stall1", bus.hazard_detected, 1);
    pv = bus.pending; chk("nofwd_pend1", pv[1], 1); cyc();
    drive(1, 1, 1, 2'b11, 1, 2, LAT_ALU, 0, 0);
    chk("nofwd_stall2", bus.hazard_detected, 1);
    pv = bus.pending; chk("nofwd_pend2", pv[1], 1); cyc();
    drive(1, 1, 1, 2'b11, 1, 2, LAT_ALU, 0, 0);
    chk("nofwd_issue", bus.hazard_detected, 0);
    pv = bus.pending; chk("nofwd_pend3", pv[1], 0); cyc();
    drain(3);

    // forwarding on: ALU no stall, load one stall
    drive(1, 0, 0, 2'b00, 1, 1, LAT_ALU, 1, 0); cyc();
    drive(1, 1, 0, 2'b01, 0, 0, 0, 1, 0);
    chk("fwd_alu_nostall", bus.hazard_detected, 0); cyc();
    drive(1, 0, 0, 2'b00, 1, 1, LAT_LOAD, 1, 0); cyc();
    drive(1, 1, 0, 2'b01, 0, 0, 0, 1, 0);
    chk("fwd_load_stall", bus.hazard_detected, 1); cyc();
    drive(1, 1, 0, 2'b01, 0, 0, 0, 1, 0);
    chk("fwd_load_release", bus.hazard_detected, 0); cyc();
    drain(3);

    // unused operands: MOVI R2 ignores pending R0; STR sees R2 on slot 1
    drive(1, 0, 0, 2'b00, 1, 0, 0, 0, 0); cyc();
    drive(1, 0, 0, 2'b00, 1, 2, 0, 0, 0);
    chk("movi_nohaz", bus.hazard_detected, 0); cyc();
    drive(1, 4, 2, 2'b11, 0, 0, 0, 0, 0);
    chk("str_haz_src", bus.hazard_src, 2'b10); cyc();
    drain(3);

    // WAW max kept (cnt[3]=3), flush records nothing
    drive(1, 0, 0, 2'b00, 1, 3, 4, 1, 0); cyc();
    drive(1, 0, 0, 2'b00, 1, 3, 1, 1, 0); cyc();
    drive(1, 3, 0, 2'b01, 0, 0, 0, 1, 0);
    chk("waw_stall1", bus.hazard_detected, 1); cyc();
    drive(1, 3, 0, 2'b01, 1, 5, 3, 1, 1);
    chk("flush_nohaz", bus.hazard_detected, 0); cyc();
    drive(1, 3, 0, 2'b01, 0, 0, 0, 1, 0);
    chk("waw_stall3", bus.hazard_detected, 1);
    pv = bus.pending; chk("flush_norecord", pv[5], 0); cyc();
    drive(1, 3, 0, 2'b01, 0, 0, 0, 1, 0);
    chk("waw_release", bus.hazard_detected, 0); cyc();
    drain(3);

    // asynchronous reset mid-run with cnt[1]=2
    drive(1, 0, 0, 2'b00, 1, 1, 0, 0, 0); cyc();
    drive(1, 1, 1, 2'b11, 0, 0, 0, 0, 0);
    chk("pre_reset_haz", bus.hazard_detected, 1);
    rst_n = 1'b0; #1;
    chk("async_rst_pending", bus.pending, 0);
    chk("async_rst_hazard", bus.hazard_detected, 0);
    model_clear();
    idle();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef HAZARD_STATS_EN
    // two separate stalls of 2 and 1 cycles
    drive(1, 0, 0, 2'b00, 1, 1, 0, 0, 0); cyc();
    repeat (3) begin drive(1, 1, 0, 2'b01, 0, 0, 0, 0, 0); cyc(); end
    drive(1, 0, 0, 2'b00, 1, 6, LAT_LOAD, 1, 0); cyc();
    repeat (2) begin drive(1, 6, 0, 2'b01, 0, 0, 0, 1, 0); cyc(); end
    idle();
    chk("stats_cycles_lit", stall_cycles, 3);
    chk("stats_events_lit", stall_events, 2);
`endif

    // randomized traffic on a small register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 5), $urandom_range(0, 5),
            2'($urandom_range(0, 3)), $urandom_range(0, 9) < 7,
            $urandom_range(0, 5), $urandom_range(0, MAX_LAT),
            $urandom_range(0, 1), $urandom_range(0, 9) == 0);
      cyc();
    end
    drain(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
